// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector arbiter.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_FINISH,
        S_RETRY
    } arb_state_t;

    localparam logic [23:0] WDOG_DEFAULT = 24'd8_000_000;

    // Index width for n items, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sd_rr_picker.sv
// Round-robin first-set search: scans req starting at ptr, wrapping once.
module sd_rr_picker
    import sd_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int unsigned j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector engine between NREQ requesters: round-robin grant,
// strobe sequencing, byte steering, retry on failure and a hang watchdog.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter logic [23:0] WDOG_CYCLES = WDOG_DEFAULT,
    parameter int unsigned RETRIES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [32*NREQ-1:0]   req_sector,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [NREQ-1:0]      rd_valid,
    output logic [NREQ-1:0]      wr_adv,
    output logic [8:0]           byte_addr,
    output logic [7:0]           rd_byte,
    input  logic [8*NREQ-1:0]    wr_byte,
    output logic                 ready,
    output logic                 sd_rstart,
    output logic                 sd_wstart,
    output logic [31:0]          sd_sector,
    output logic [7:0]           sd_inbyte,
    input  logic                 sd_busy,
    input  logic                 sd_done,
    input  logic                 sd_outen,
    input  logic [8:0]           sd_outaddr,
    input  logic [7:0]           sd_outbyte
);

    localparam int unsigned IW = clog2(NREQ);
    localparam int unsigned RW = clog2(RETRIES + 1);

    arb_state_t      state, state_nx;
    logic [IW-1:0]   owner, rr;
    logic            we_q;
    logic [31:0]     sector_q;
    logic [RW-1:0]   retry_cnt;
    logic [23:0]     wdog;
    logic [NREQ-1:0] gnt_q, done_q, err_q;

    logic [NREQ-1:0] req_eff, pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any, can_grant, wdog_hit, retry_left, active;

    // The finishing owner still holds req during its done/err cycle; mask it
    // so a lone requester is not granted again before it can drop req.
    assign req_eff    = req & ~(done_q | err_q);
    assign can_grant  = (state == S_IDLE) && !sd_busy && pick_any;
    assign wdog_hit   = (wdog >= WDOG_CYCLES - 24'd1);
    assign retry_left = (32'(retry_cnt) < RETRIES);

    sd_rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (req_eff),
        .ptr    (rr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        sd_rstart = 1'b0;
        sd_wstart = 1'b0;
        case (state)
            S_INIT:   if (!sd_busy) state_nx = S_IDLE;
            S_IDLE: begin
                ready = !sd_busy;
                if (can_grant) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                sd_rstart = !sd_busy && !we_q;
                sd_wstart = !sd_busy && we_q;
                if (wdog_hit)     state_nx = S_RETRY;
                else if (sd_busy) state_nx = S_RUN;
            end
            S_RUN: begin
                if (wdog_hit)      state_nx = S_RETRY;
                else if (!sd_busy) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = sd_done ? S_IDLE : S_RETRY;
            S_RETRY:  state_nx = retry_left ? S_ISSUE : S_IDLE;
            default:  state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            owner     <= '0;
            rr        <= '0;
            we_q      <= 1'b0;
            sector_q  <= '0;
            retry_cnt <= '0;
            wdog      <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state  <= state_nx;
            done_q <= '0;
            err_q  <= '0;
            if (can_grant) begin
                owner     <= pick_idx;
                we_q      <= req_we[pick_idx];
                sector_q  <= req_sector[32*pick_idx +: 32];
                gnt_q     <= pick_onehot;
                retry_cnt <= '0;
                rr        <= (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IW'(1);
            end
            if (state_nx == S_ISSUE && state != S_ISSUE)
                wdog <= '0;
            else if (state == S_ISSUE || state == S_RUN)
                wdog <= wdog + 24'd1;
            if (state == S_RETRY && retry_left)
                retry_cnt <= retry_cnt + RW'(1);
            if (state == S_FINISH && sd_done) begin
                done_q <= gnt_q;
                gnt_q  <= '0;
            end
            if (state == S_RETRY && !retry_left) begin
                err_q <= gnt_q;
                gnt_q <= '0;
            end
        end
    end

    // gnt_q is the one-hot owner and is zero whenever nothing is in flight.
    assign active    = |gnt_q;
    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_valid  = (sd_outen && !we_q) ? gnt_q : '0;
    assign wr_adv    = (sd_outen && we_q)  ? gnt_q : '0;
    assign byte_addr = active ? sd_outaddr : '0;
    assign rd_byte   = active ? sd_outbyte : '0;
    assign sd_inbyte = wr_byte[8*owner +: 8];
    assign sd_sector = sector_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter with a behavioural SD engine model.
module tb_sd_sector_arbiter;

    localparam int unsigned NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_v [NREQ];
    logic              we_v  [NREQ];
    logic [31:0]       sec_v [NREQ];
    logic [NREQ-1:0]   req, req_we;
    logic [32*NREQ-1:0] req_sector;
    logic [8*NREQ-1:0] wr_byte;
    logic [NREQ-1:0]   gnt, done, err, rd_valid, wr_adv;
    logic [8:0]        byte_addr;
    logic [7:0]        rd_byte, sd_inbyte;
    logic              ready, sd_rstart, sd_wstart;
    logic [31:0]       sd_sector;
    logic              sd_busy, sd_done, sd_outen;
    logic [8:0]        sd_outaddr;
    logic [7:0]        sd_outbyte;

    assign req        = {req_v[1], req_v[0]};
    assign req_we     = {we_v[1], we_v[0]};
    assign req_sector = {sec_v[1], sec_v[0]};
    assign wr_byte    = {sd_outaddr[7:0] ^ 8'hA5, 8'h3C};

    sd_sector_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(24'd1000), .RETRIES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_sector(req_sector),
        .gnt(gnt), .done(done), .err(err), .rd_valid(rd_valid), .wr_adv(wr_adv),
        .byte_addr(byte_addr), .rd_byte(rd_byte), .wr_byte(wr_byte), .ready(ready),
        .sd_rstart(sd_rstart), .sd_wstart(sd_wstart), .sd_sector(sd_sector),
        .sd_inbyte(sd_inbyte), .sd_busy(sd_busy), .sd_done(sd_done),
        .sd_outen(sd_outen), .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte)
    );

    int checks = 0;
    int errors = 0;
    int mode = 0;          // engine: 0 normal, 1 completes with failure, 2 hung
    int strobe_cnt = 0;

    typedef struct { int idx; logic we; logic [31:0] sec; } gexp_t;
    typedef struct { logic is_err; int idx; int nbytes; } eexp_t;
    gexp_t exp_gnt [$];
    eexp_t exp_end [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: accepts a strobe, raises busy, streams 512 bytes, drops busy.
    initial begin : engine
        sd_busy = 1'b1; sd_done = 1'b0; sd_outen = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
        wait (rst == 1'b0);
        repeat (1000) @(posedge clk);
        #1 sd_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst && mode != 2 && (sd_rstart || sd_wstart)) begin
                sd_done = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("strobe_held", 64'(sd_rstart | sd_wstart), 64'd1);
                sd_busy = 1'b1;
                if (mode == 0) begin
                    for (int a = 0; a < 512; a++) begin
                        @(posedge clk); #1;
                        sd_outen = 1'b1; sd_outaddr = 9'(a); sd_outbyte = 8'(a);
                    end
                end else begin
                    repeat (3) @(posedge clk);
                end
                @(posedge clk); #1;
                sd_outen = 1'b0;
                sd_busy  = 1'b0;
                sd_done  = (mode == 0);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants, strobes a byte or ends.
    initial begin : monitor
        logic [NREQ-1:0] prev_gnt, exp_oh, e_rv, e_wa, zero_v;
        logic            prev_stb, cur_we;
        logic [8:0]      exp_addr;
        logic [7:0]      e_b, a_b;
        int              cur_owner, nbytes;
        gexp_t           g;
        eexp_t           e;
        prev_gnt = '0; prev_stb = 1'b0; cur_we = 1'b0; cur_owner = 0;
        exp_addr = '0; nbytes = 0; zero_v = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ((sd_rstart || sd_wstart) && !prev_stb) strobe_cnt++;
                if (gnt != 0 && prev_gnt == 0) begin
                    if (exp_gnt.size() == 0) begin
                        check("unexpected_gnt", 64'(gnt), 64'd0);
                    end else begin
                        g = exp_gnt.pop_front();
                        cur_owner = g.idx; cur_we = g.we; exp_addr = '0; nbytes = 0;
                        check("gnt", 64'(gnt), 64'(NREQ'(1) << g.idx));
                        check("sd_sector", 64'(sd_sector), 64'(g.sec));
                        check("strobe_kind", 64'({sd_rstart, sd_wstart}), g.we ? 64'd1 : 64'd2);
                    end
                end
                if (rd_valid != 0 || wr_adv != 0) begin
                    exp_oh = NREQ'(1) << cur_owner;
                    e_rv = cur_we ? zero_v : exp_oh;
                    e_wa = cur_we ? exp_oh : zero_v;
                    e_b  = cur_we ? (exp_addr[7:0] ^ 8'hA5) : exp_addr[7:0];
                    a_b  = cur_we ? sd_inbyte : rd_byte;
                    check("byte_strobe", 64'({rd_valid, wr_adv, byte_addr, a_b}),
                          64'({e_rv, e_wa, exp_addr, e_b}));
                    exp_addr = exp_addr + 9'd1;
                    nbytes++;
                end
                if (done != 0 || err != 0) begin
                    if (exp_end.size() == 0) begin
                        check("unexpected_end", 64'({done, err}), 64'd0);
                    end else begin
                        e = exp_end.pop_front();
                        exp_oh = NREQ'(1) << e.idx;
                        check("end_pulse", 64'({done, err}),
                              e.is_err ? 64'({zero_v, exp_oh}) : 64'({exp_oh, zero_v}));
                        check("byte_count", 64'(nbytes), 64'(e.nbytes));
                    end
                end
            end
            prev_gnt = rst ? '0 : gnt;
            prev_stb = rst ? 1'b0 : (sd_rstart || sd_wstart);
        end
    end

    task automatic drive_req(input int idx, input logic we, input logic [31:0] sec, output int n);
        logic seen;
        @(posedge clk); #1;
        we_v[idx] = we; sec_v[idx] = sec; req_v[idx] = 1'b1;
        n = 0; seen = 1'b0;
        while (n < 20000 && !seen) begin
            @(negedge clk);
            n++;
            seen = done[idx] || err[idx];
        end
        req_v[idx] = 1'b0;
        check("req_complete", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 64'({gnt, done, err, rd_valid, wr_adv, ready, sd_rstart, sd_wstart,
                         sd_sector, byte_addr}), 64'd0);
    endtask

    initial begin : stim
        int n, bad, s0;
        for (int i = 0; i < NREQ; i++) begin req_v[i] = 1'b0; we_v[i] = 1'b0; sec_v[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;

        // Card init: no grant or ready while busy, even with a request posted.
        req_v[0] = 1'b1;
        n = 0; bad = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (!sd_busy) break;
            if (gnt != 0 || ready) bad++;
            n++;
            if (n == 900) req_v[0] = 1'b0;
        end
        check("init_no_grant", 64'(bad), 64'd0);
        check("ready_at_busy_fall", 64'(ready), 64'd0);
        @(negedge clk);
        check("ready_after_busy_fall", 64'(ready), 64'd1);

        // Single read of sector 0x10 by requester 0.
        exp_gnt.push_back('{0, 1'b0, 32'h10});
        exp_end.push_back('{1'b0, 0, 512});
        drive_req(0, 1'b0, 32'h10, n);

        // Write of sector 5 by requester 1; leaves the rr pointer at 0.
        exp_gnt.push_back('{1, 1'b1, 32'h5});
        exp_end.push_back('{1'b0, 1, 512});
        drive_req(1, 1'b1, 32'h5, n);

        // Simultaneous reads, then requester 0 re-requests while 1 is pending.
        exp_gnt.push_back('{0, 1'b0, 32'h20});
        exp_gnt.push_back('{1, 1'b0, 32'h21});
        exp_gnt.push_back('{0, 1'b0, 32'h22});
        exp_end.push_back('{1'b0, 0, 512});
        exp_end.push_back('{1'b0, 1, 512});
        exp_end.push_back('{1'b0, 0, 512});
        fork
            begin
                int n0;
                drive_req(0, 1'b0, 32'h20, n0);
                drive_req(0, 1'b0, 32'h22, n0);
            end
            begin
                int n1;
                drive_req(1, 1'b0, 32'h21, n1);
            end
        join

        // Engine always reports failure: three strobes then err.
        mode = 1;
        s0 = strobe_cnt;
        exp_gnt.push_back('{0, 1'b0, 32'h7});
        exp_end.push_back('{1'b1, 0, 0});
        drive_req(0, 1'b0, 32'h7, n);
        check("fail_strobes", 64'(strobe_cnt - s0), 64'd3);
        check("fail_ready", 64'(ready), 64'd1);

        // Hung engine: three 1000-cycle watchdog attempts then err.
        mode = 2;
        s0 = strobe_cnt;
        exp_gnt.push_back('{1, 1'b0, 32'h9});
        exp_end.push_back('{1'b1, 1, 0});
        drive_req(1, 1'b0, 32'h9, n);
        check("wdog_strobes", 64'(strobe_cnt - s0), 64'd3);
        check("wdog_latency", 64'(n), 64'd3005);

        // Reset during the second watchdog attempt abandons the request silently.
        exp_gnt.push_back('{0, 1'b0, 32'hB});
        @(posedge clk); #1;
        sec_v[0] = 32'hB; we_v[0] = 1'b0; req_v[0] = 1'b1;
        repeat (1500) @(posedge clk);
        #1 rst = 1'b1; req_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midop_reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        check("end_queue_empty", 64'(exp_end.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
